// File: rtl/hv_decode.sv
// hv_decode: video timing decoder.
// Registers hsync/vsync/data_en, produces pixel coordinates one cycle after
// each active pixel, flags line-width and frame-height mismatches against
// ACTIVE_W/ACTIVE_H, and runs a lock FSM over frame boundaries.
// Optional feature macro: HV_DECODE_MEASURE_EN adds meas_hp/meas_vp, which
// report the measured hsync period and the number of lines per frame.
module hv_decode #(
  parameter int ACTIVE_W = 1024,
  parameter int ACTIVE_H = 600
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        data_en,
  output logic        px_valid,
  output logic [10:0] px_x,
  output logic [9:0]  px_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        err_width,
  output logic        err_height,
  output logic        locked
`ifdef HV_DECODE_MEASURE_EN
  ,
  output logic [11:0] meas_hp,
  output logic [10:0] meas_vp
`endif
);

  localparam logic [10:0] W_EXP = 11'(ACTIVE_W);
  localparam logic [9:0]  H_EXP = 10'(ACTIVE_H);
  localparam logic [10:0] X_MAX = 11'h7FF;
  localparam logic [9:0]  Y_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  // Input history and edge detection
  logic        r_vs_d;
  logic        r_de_d;
  logic        w_de_rise;
  logic        w_de_fall;
  logic        w_vs_rise;

  // Datapath registers
  logic        r_px_valid;
  logic [10:0] r_px_x;
  logic [9:0]  r_px_y;
  logic        r_line_start;
  logic [10:0] r_line_cnt;   // active cycles seen in the current line
  logic [9:0]  r_y;          // completed lines in the current frame

  // Frame checks
  logic        r_frame_start;
  logic        r_err_width;
  logic        r_err_height;
  logic        r_frame_seen; // a vs_rise has occurred since reset
  logic        r_frame_err;  // width error seen in the frame in progress

  // Lock FSM
  lock_state_t r_state;
  logic        r_locked;

  logic [9:0]  w_y_cur;
  logic [9:0]  w_y_inc;
  logic [9:0]  w_frame_lines;
  logic        w_width_bad;
  logic        w_height_bad;
  logic        w_frame_bad;

  assign w_de_rise = data_en & ~r_de_d;
  assign w_de_fall = ~data_en & r_de_d;
  assign w_vs_rise = vsync & ~r_vs_d;

  // A frame boundary in the same cycle as a line start clears first, so the
  // new line is reported as line 0.
  assign w_y_cur       = w_vs_rise ? 10'd0 : r_y;
  assign w_y_inc       = (r_y == Y_MAX) ? r_y : r_y + 10'd1;
  // A line ending in the vs_rise cycle still belongs to the frame closing.
  assign w_frame_lines = w_de_fall ? w_y_inc : r_y;

  // Saturated counts cannot represent the true length, so they never match.
  assign w_width_bad  = (r_line_cnt == X_MAX) || (r_line_cnt != W_EXP);
  assign w_height_bad = (w_frame_lines == Y_MAX) || (w_frame_lines != H_EXP);

  // A frame is bad if any width error was flagged in it, including one
  // reported in the same cycle as the closing frame_start.
  assign w_frame_bad = r_frame_err | r_err_width | r_err_height;

  // Edge registers, pixel coordinates and line counting
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; the asynchronous reset clears it at once.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_vs_d       <= 1'b0;
      r_de_d       <= 1'b0;
      r_px_valid   <= 1'b0;
      r_px_x       <= 11'd0;
      r_px_y       <= 10'd0;
      r_line_start <= 1'b0;
      r_line_cnt   <= 11'd0;
      r_y          <= 10'd0;
    end else begin
      r_vs_d       <= vsync;
      r_de_d       <= data_en;
      r_px_valid   <= data_en;
      r_line_start <= w_de_rise;
      if (w_de_rise) begin
        r_px_x     <= 11'd0;
        r_line_cnt <= 11'd1;
      end else if (data_en) begin
        r_px_x     <= (r_px_x == X_MAX) ? r_px_x : r_px_x + 11'd1;
        r_line_cnt <= (r_line_cnt == X_MAX) ? r_line_cnt : r_line_cnt + 11'd1;
      end
      if (data_en) begin
        r_px_y <= w_y_cur;
      end
      if (w_vs_rise) begin
        r_y <= 10'd0;
      end else if (w_de_fall) begin
        r_y <= w_y_inc;
      end
    end
  end

  // Frame/line boundary pulses and geometry error pulses
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_frame_start <= 1'b0;
      r_err_width   <= 1'b0;
      r_err_height  <= 1'b0;
      r_frame_seen  <= 1'b0;
    end else begin
      r_frame_start <= w_vs_rise;
      r_err_width   <= w_de_fall & w_width_bad;
      r_err_height  <= w_vs_rise & r_frame_seen & w_height_bad;
      if (w_vs_rise) begin
        r_frame_seen <= 1'b1;
      end
    end
  end

  // Lock FSM, driven by the registered frame_start and error pulses
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ST_UNLOCKED;
      r_locked    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (r_frame_start) begin
        r_frame_err <= 1'b0;
      end else if (r_err_width) begin
        r_frame_err <= 1'b1;
      end
      case (r_state)
        ST_UNLOCKED: begin
          if (r_frame_start) begin
            r_state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (r_frame_start && !w_frame_bad) begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (r_err_width || r_err_height) begin
            r_state  <= ST_SYNC;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_UNLOCKED;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign px_valid    = r_px_valid;
  assign px_x        = r_px_x;
  assign px_y        = r_px_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign err_width   = r_err_width;
  assign err_height  = r_err_height;
  assign locked      = r_locked;

`ifdef HV_DECODE_MEASURE_EN
  logic        r_hs_d;
  logic        r_hs_seen;
  logic [11:0] r_hp_cnt;
  logic [11:0] r_meas_hp;
  logic [10:0] r_vp_cnt;
  logic [10:0] r_meas_vp;
  logic        w_hs_rise;

  assign w_hs_rise = hsync & ~r_hs_d;

  // Measure hsync period in clocks and hsync rises per vsync period
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_hs_d    <= 1'b0;
      r_hs_seen <= 1'b0;
      r_hp_cnt  <= 12'd0;
      r_meas_hp <= 12'd0;
      r_vp_cnt  <= 11'd0;
      r_meas_vp <= 11'd0;
    end else begin
      r_hs_d <= hsync;
      if (w_hs_rise) begin
        if (r_hs_seen) begin
          r_meas_hp <= r_hp_cnt;
        end
        r_hs_seen <= 1'b1;
        r_hp_cnt  <= 12'd1;
      end else if (r_hp_cnt != 12'hFFF) begin
        r_hp_cnt <= r_hp_cnt + 12'd1;
      end
      // An hsync rise coinciding with vsync rise opens the new frame's count.
      if (w_vs_rise) begin
        if (r_frame_seen) begin
          r_meas_vp <= r_vp_cnt;
        end
        r_vp_cnt <= w_hs_rise ? 11'd1 : 11'd0;
      end else if (w_hs_rise && (r_vp_cnt != 11'h7FF)) begin
        r_vp_cnt <= r_vp_cnt + 11'd1;
      end
    end
  end

  assign meas_hp = r_meas_hp;
  assign meas_vp = r_meas_vp;
`else
  // hsync feeds only the measurement logic, which is not built here.
  logic w_unused_hsync;
  assign w_unused_hsync = hsync;
`endif

endmodule
